// File: rtl/mxv_frame_parser_if.sv
// Byte-in / FIFO-out bundle of the MxV frame parser.
// master = parser side, slave = UART/FIFO side.
interface mxv_frame_parser_if #(
  parameter int DW    = 8,
  parameter int N_MAX = 8
) ();
  logic                         rx_valid;
  logic [DW-1:0]                rx_data;
  logic                         rx_err;
  logic [N_MAX-1:0]             row_full;
  logic                         vec_full;
  logic [N_MAX-1:0]             row_wr;
  logic                         vec_wr;
  logic [DW-1:0]                wdata;
  logic                         fifo_flush;
  logic [$clog2(N_MAX+1)-1:0]   n_cfg;
  logic                         start_p;
  logic                         repeat_p;
  logic                         frame_ok;
  logic                         frame_err;
  logic [2:0]                   err_code;
  logic                         busy;

  modport master (
    input  rx_valid, rx_data, rx_err,
    input  row_full, vec_full,
    output row_wr, vec_wr, wdata, fifo_flush,
    output n_cfg, start_p, repeat_p,
    output frame_ok, frame_err, err_code, busy
  );

  modport slave (
    output rx_valid, rx_data, rx_err,
    output row_full, vec_full,
    input  row_wr, vec_wr, wdata, fifo_flush,
    input  n_cfg, start_p, repeat_p,
    input  frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/mxv_frame_parser.sv
// Length-checked FE,L,CMD,payload,EF frame decoder that steers
// matrix/vector elements into FIFOs and commits control on EOF.
module mxv_frame_parser #(
  parameter int            DW          = 8,
  parameter int            N_MAX       = 8,
  parameter int            TIMEOUT_CYC = 4096,
  parameter logic [DW-1:0] SOF         = DW'(8'hFE),
  parameter logic [DW-1:0] EOF         = DW'(8'hEF)
) (
  input logic                clk,
  input logic                rst,
  mxv_frame_parser_if.master bus
);

  localparam int NW = $clog2(N_MAX + 1);
  localparam int MW = 2 * NW;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] C_START = 3'd1;
  localparam logic [2:0] C_REP   = 3'd2;
  localparam logic [2:0] C_SIZE  = 3'd3;
  localparam logic [2:0] C_MAT   = 3'd4;
  localparam logic [2:0] C_VEC   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_CMD, S_PAY,
    S_EOF, S_COMMIT, S_ABORT
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [NW-1:0]    lane_q, lane_d;
  logic [NW-1:0]    nsh_q, nsh_d;
  logic [NW-1:0]    ncfg_q, ncfg_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [2:0]       err_q, err_d;
  logic [N_MAX-1:0] row_wr_q, row_wr_d;
  logic             vec_wr_q, vec_wr_d;
  logic [DW-1:0]    wdata_q, wdata_d;

  logic [MW-1:0]    nn;
  logic [7:0]       rx_b;
  logic [7:0]       l_req;
  logic [N_MAX-1:0] lane_oh;
  logic             cmd_ok;
  logic             need_n;
  logic             n_ok;
  logic             lane_full;
  logic             abort;
  logic [2:0]       code;

  assign rx_b      = 8'(bus.rx_data);
  assign nn        = MW'(ncfg_q) * MW'(ncfg_q);
  assign cmd_ok    = bus.rx_data >= DW'(1) &&
                     bus.rx_data <= DW'(5);
  assign need_n    = rx_b[2:0] == C_MAT ||
                     rx_b[2:0] == C_VEC;
  assign n_ok      = bus.rx_data != '0 &&
                     bus.rx_data <= DW'(N_MAX);
  assign lane_oh   = N_MAX'(1) << lane_q;
  assign lane_full = |(bus.row_full & lane_oh);

  always_comb begin
    l_req = 8'd1;
    unique case (rx_b[2:0])
      C_SIZE:  l_req = 8'd2;
      C_MAT:   l_req = 8'(nn) + 8'd1;
      C_VEC:   l_req = 8'(ncfg_q) + 8'd1;
      default: l_req = 8'd1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    lane_d   = lane_q;
    nsh_d    = nsh_q;
    ncfg_d   = ncfg_q;
    tmo_d    = '0;
    err_d    = err_q;
    row_wr_d = '0;
    vec_wr_d = 1'b0;
    wdata_d  = wdata_q;
    abort    = 1'b0;
    code     = 3'd0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && bus.rx_data == SOF) begin
          state_d = S_LEN;
          lane_d  = '0;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (cmd_q == C_SIZE) ncfg_d = nsh_q;
      end
      S_ABORT: state_d = S_IDLE;
      default: begin
        tmo_d = tmo_q + TW'(1);
        // rx_err outranks both a byte and the timeout
        if (bus.rx_err) begin
          abort = 1'b1;
          code  = 3'd7;
        end else if (bus.rx_valid) begin
          tmo_d = '0;
          if (state_q == S_LEN) begin
            len_d   = rx_b;
            state_d = S_CMD;
          end else if (state_q == S_CMD) begin
            cmd_d = rx_b[2:0];
            if (!cmd_ok) begin
              abort = 1'b1;
              code  = 3'd2;
            end else if (need_n && ncfg_q == '0) begin
              abort = 1'b1;
              code  = 3'd3;
            end else if (len_q != l_req) begin
              abort = 1'b1;
              code  = 3'd1;
            end else begin
              cnt_d   = len_q - 8'd1;
              state_d = (len_q == 8'd1) ? S_EOF : S_PAY;
            end
          end else if (state_q == S_PAY) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = S_EOF;
            unique case (1'b1)
              cmd_q == C_SIZE: begin
                if (n_ok) nsh_d = NW'(bus.rx_data);
                else begin
                  abort = 1'b1;
                  code  = 3'd3;
                end
              end
              cmd_q == C_MAT: begin
                if (lane_full) begin
                  abort = 1'b1;
                  code  = 3'd5;
                end else begin
                  row_wr_d = lane_oh;
                  wdata_d  = bus.rx_data;
                  lane_d   = (lane_q + NW'(1) == ncfg_q)
                           ? '0 : lane_q + NW'(1);
                end
              end
              cmd_q == C_VEC: begin
                if (bus.vec_full) begin
                  abort = 1'b1;
                  code  = 3'd5;
                end else begin
                  vec_wr_d = 1'b1;
                  wdata_d  = bus.rx_data;
                end
              end
              default: ;
            endcase
          end else begin
            if (bus.rx_data == EOF) state_d = S_COMMIT;
            else begin
              abort = 1'b1;
              code  = 3'd4;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          abort = 1'b1;
          code  = 3'd6;
        end
      end
    endcase
    if (abort) begin
      state_d = S_ABORT;
      err_d   = code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      cmd_q    <= '0;
      lane_q   <= '0;
      nsh_q    <= '0;
      ncfg_q   <= '0;
      tmo_q    <= '0;
      err_q    <= '0;
      row_wr_q <= '0;
      vec_wr_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      lane_q   <= lane_d;
      nsh_q    <= nsh_d;
      ncfg_q   <= ncfg_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      row_wr_q <= row_wr_d;
      vec_wr_q <= vec_wr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.row_wr     = row_wr_q;
  assign bus.vec_wr     = vec_wr_q;
  assign bus.wdata      = wdata_q;
  assign bus.n_cfg      = ncfg_q;
  assign bus.err_code   = err_q;
  assign bus.busy       = state_q != S_IDLE;
  assign bus.frame_ok   = state_q == S_COMMIT;
  assign bus.start_p    = state_q == S_COMMIT &&
                          cmd_q == C_START;
  assign bus.repeat_p   = state_q == S_COMMIT &&
                          cmd_q == C_REP;
  assign bus.frame_err  = state_q == S_ABORT;
  assign bus.fifo_flush = state_q == S_ABORT;

endmodule

// File: tb/tb_mxv_frame_parser.sv
// Bench for mxv_frame_parser: frame table, corner sequences
// and random frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_mxv_frame_parser;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mxv_frame_parser_if #(.DW(8), .N_MAX(8)) bus ();

  mxv_frame_parser #(
    .DW(8), .N_MAX(8), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  int n_ok, n_err, n_st, n_rp, n_fl, n_oh;
  int code_seen;
  int row_q[$];
  int vec_q[$];

  always @(negedge clk) begin
    int li;
    int c;
    li = 0;
    c = 0;
    for (int i = 0; i < 8; i++)
      if (bus.row_wr[i]) begin
        li = i;
        c++;
      end
    if (c > 1) n_oh++;
    if (c != 0) row_q.push_back(li * 256 + int'(bus.wdata));
    if (bus.vec_wr) vec_q.push_back(int'(bus.wdata));
    if (bus.frame_ok) n_ok++;
    if (bus.frame_err) begin
      n_err++;
      code_seen = int'(bus.err_code);
    end
    if (bus.start_p) n_st++;
    if (bus.repeat_p) n_rp++;
    if (bus.fifo_flush) n_fl++;
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic clr();
    n_ok = 0; n_err = 0; n_st = 0;
    n_rp = 0; n_fl = 0; n_oh = 0;
    code_seen = 0;
    row_q.delete();
    vec_q.delete();
  endtask

  task automatic drive(input logic v,
                       input logic [7:0] d,
                       input logic e);
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.rx_err   = e;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [95:0] w, input int nb);
    for (int j = 0; j < nb; j++)
      drive(1'b1, w[8*(nb-1-j) +: 8], 1'b0);
  endtask

  function automatic logic [23:0] outc(int ok, int er, int cd,
                                       int st, int rp, int fl);
    return {4'(ok), 4'(er), 4'(cd), 4'(st), 4'(rp), 4'(fl)};
  endfunction

  // ---------------- reference model -----------------
  logic [7:0] fr[$];
  int         m_n;
  logic [7:0] m_rf;
  logic       m_vf;
  int m_ok, m_code, m_st, m_rp, m_used;
  int exp_row[$];
  int exp_vec[$];
  logic [7:0] badc [7] = '{8'h00, 8'h06, 8'h07, 8'hFE,
                           8'hEF, 8'hFF, 8'h81};

  function automatic int req_len(int c, int n);
    if (c == 3) return 2;
    if (c == 4) return (n * n + 1) % 256;
    if (c == 5) return n + 1;
    return 1;
  endfunction

  task automatic gen_frame();
    int kind, c, l, eb;
    fr.delete();
    kind = $urandom_range(0, 7);
    c = (kind == 0) ? 1 : (kind == 1) ? 2 :
        (kind == 2) ? 3 : (kind <= 4) ? 4 : 5;
    l = req_len(c, m_n);
    if ((c == 4 || c == 5) && m_n == 0) l = $urandom_range(1, 3);
    if (kind == 6) begin
      c = int'(badc[$urandom_range(0, 6)]);
      l = $urandom_range(1, 3);
    end
    if (kind == 7) begin
      c = $urandom_range(1, 5);
      l = req_len(c, m_n) + $urandom_range(1, 3);
    end
    fr.push_back(8'hFE);
    fr.push_back(8'(l));
    fr.push_back(8'(c));
    for (int k = 0; k < l - 1; k++)
      fr.push_back(c == 3 ? 8'($urandom_range(0, 9))
                          : 8'($urandom_range(0, 255)));
    eb = 8'hEF;
    if ($urandom_range(0, 9) == 0) eb = $urandom_range(0, 8'hEE);
    fr.push_back(8'(eb));
  endtask

  task automatic model_frame();
    int l, c, sh, b;
    m_ok = 0; m_code = 0; m_st = 0; m_rp = 0; m_used = 3;
    exp_row.delete();
    exp_vec.delete();
    l = int'(fr[1]);
    c = int'(fr[2]);
    sh = m_n;
    if (c < 1 || c > 5) m_code = 2;
    else if ((c == 4 || c == 5) && m_n == 0) m_code = 3;
    else if (l != req_len(c, m_n)) m_code = 1;
    else begin
      for (int k = 0; k < l - 1 && m_code == 0; k++) begin
        b = int'(fr[3 + k]);
        m_used++;
        if (c == 3) begin
          if (b == 0 || b > 8) m_code = 3;
          else sh = b;
        end else if (c == 4) begin
          if (m_rf[k % m_n]) m_code = 5;
          else exp_row.push_back((k % m_n) * 256 + b);
        end else if (c == 5) begin
          if (m_vf) m_code = 5;
          else exp_vec.push_back(b);
        end
      end
      if (m_code == 0) begin
        m_used++;
        if (fr[2 + l] == 8'hEF) begin
          m_ok = 1;
          m_st = int'(c == 1);
          m_rp = int'(c == 2);
          if (c == 3) m_n = sh;
        end else m_code = 4;
      end
    end
  endtask

  // ---------------- frame table -----------------
  typedef struct {
    logic [95:0] fr;
    int nb;
    logic [7:0] rf;
    logic vf;
    int ok, code, st, rp, nwr, ncfg;
  } tv_t;
  tv_t tv[22];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, mism;
    logic [95:0] w;
    tv[0]  = '{96'hFE0104, 3, 8'h00, 1'b0, 0, 3, 0, 0, 0, 0};
    tv[1]  = '{96'hFE020303EF, 5, 8'h00, 1'b0, 1, 0, 0, 0, 0, 3};
    tv[2]  = '{96'hFE0101EF, 4, 8'h00, 1'b0, 1, 0, 1, 0, 0, 3};
    tv[3]  = '{96'hFE0102EF, 4, 8'h00, 1'b0, 1, 0, 0, 1, 0, 3};
    tv[4]  = '{96'hFE010200, 4, 8'h00, 1'b0, 0, 4, 0, 0, 0, 3};
    tv[5]  = '{96'hFE0201, 3, 8'h00, 1'b0, 0, 1, 0, 0, 0, 3};
    tv[6]  = '{96'hFE0107, 3, 8'h00, 1'b0, 0, 2, 0, 0, 0, 3};
    tv[7]  = '{96'hFE0100, 3, 8'h00, 1'b0, 0, 2, 0, 0, 0, 3};
    tv[8]  = '{96'hFE020300, 4, 8'h00, 1'b0, 0, 3, 0, 0, 0, 3};
    tv[9]  = '{96'hFE020309, 4, 8'h00, 1'b0, 0, 3, 0, 0, 0, 3};
    tv[10] = '{96'hFE0405AAFEEFEF, 7, 8'h00, 1'b0,
               1, 0, 0, 0, 3, 3};
    tv[11] = '{96'hFE0305, 3, 8'h00, 1'b0, 0, 1, 0, 0, 0, 3};
    tv[12] = '{96'hFE020302EF, 5, 8'h00, 1'b0, 1, 0, 0, 0, 0, 2};
    tv[13] = '{96'hFE050411223344EF, 8, 8'h00, 1'b0,
               1, 0, 0, 0, 4, 2};
    tv[14] = '{96'hFE05041122, 5, 8'h02, 1'b0, 0, 5, 0, 0, 1, 2};
    tv[15] = '{96'hFE030555, 4, 8'h00, 1'b1, 0, 5, 0, 0, 0, 2};
    tv[16] = '{96'hFE0303, 3, 8'h00, 1'b0, 0, 1, 0, 0, 0, 2};
    tv[17] = '{96'hFE020308EF, 5, 8'h00, 1'b0, 1, 0, 0, 0, 0, 8};
    tv[18] = '{96'hFE02030400, 5, 8'h00, 1'b0, 0, 4, 0, 0, 0, 8};
    tv[19] = '{96'hFE020301EF, 5, 8'h00, 1'b0, 1, 0, 0, 0, 0, 1};
    tv[20] = '{96'hFE020477EF, 5, 8'h00, 1'b0, 1, 0, 0, 0, 1, 1};
    tv[21] = '{96'hFE0304, 3, 8'h00, 1'b0, 0, 1, 0, 0, 0, 1};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_err   = 1'b0;
    bus.row_full = 8'h00;
    bus.vec_full = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset", {bus.busy, bus.row_wr, bus.vec_wr, bus.wdata,
                    bus.fifo_flush, bus.n_cfg, bus.start_p,
                    bus.repeat_p, bus.frame_ok, bus.frame_err,
                    bus.err_code}, 64'h0);

    // idle noise and rx_err while idle are ignored
    clr();
    drive(1'b1, 8'hEF, 1'b0);
    drive(1'b1, 8'h01, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    idle(2);
    check("idle.ignore", {n_err, bus.busy}, 0);

    for (int i = 0; i < 22; i++) begin
      bus.row_full = tv[i].rf;
      bus.vec_full = tv[i].vf;
      clr();
      w = tv[i].fr;
      send(w, tv[i].nb);
      idle(3);
      check($sformatf("tbl%0d.out", i),
            outc(n_ok, n_err, code_seen, n_st, n_rp, n_fl),
            outc(tv[i].ok, 1 - tv[i].ok, tv[i].code,
                 tv[i].st, tv[i].rp, 1 - tv[i].ok));
      check($sformatf("tbl%0d.wr", i),
            row_q.size() + vec_q.size() + n_oh, tv[i].nwr);
      check($sformatf("tbl%0d.ncfg", i), bus.n_cfg, tv[i].ncfg);
    end
    bus.row_full = 8'h00;
    bus.vec_full = 1'b0;

    // matrix steering with exact write timing, n=3
    send(96'hFE020303EF, 5);
    idle(2);
    clr();
    send(96'hFE0A04, 3);
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 8'(k + 1), 1'b0);
      check($sformatf("mat%0d.lane", k),
            {bus.row_wr, bus.vec_wr, bus.wdata},
            {8'(1 << (k % 3)), 1'b0, 8'(k + 1)});
      idle(1);
      check($sformatf("mat%0d.off", k), bus.row_wr, 0);
    end
    drive(1'b1, 8'hEF, 1'b0);
    check("mat.ok", {bus.frame_ok, bus.frame_err}, 2'b10);
    idle(2);
    check("mat.cnt", {n_ok, n_err, row_q.size()}, {32'd1, 32'd0, 32'd9});

    // inter-byte timeout, then a clean REPEAT
    clr();
    send(96'hFE01, 2);
    first = -1;
    for (int i = 1; i <= TMO + 6; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      if (bus.frame_err && first < 0) first = i;
    end
    check("tmo.cycle", first, TMO);
    check("tmo.code", {code_seen, n_fl, bus.busy}, {32'd6, 32'd1, 1'b0});
    clr();
    send(96'hFE0102EF, 4);
    idle(2);
    check("tmo.repeat", {n_ok, n_rp, n_err}, {32'd1, 32'd1, 32'd0});

    // rx_err beats rx_valid in the same cycle
    clr();
    send(96'hFE01, 2);
    drive(1'b1, 8'h01, 1'b1);
    check("err.vs.valid", {bus.frame_err, bus.fifo_flush, bus.err_code},
          {1'b1, 1'b1, 3'd7});
    drive(1'b1, 8'hEF, 1'b0);
    idle(2);
    check("err.noside", {n_ok, n_st, n_err}, {32'd0, 32'd0, 32'd1});

    // rx_err beats a timeout in the same cycle
    clr();
    send(96'hFE01, 2);
    idle(TMO - 1);
    drive(1'b0, 8'h00, 1'b1);
    check("err.vs.tmo", {bus.frame_err, bus.err_code}, {1'b1, 3'd7});
    idle(2);
    check("err.vs.tmo.cnt", n_err, 1);

    // byte during COMMIT is dropped
    clr();
    send(96'hFE0101EF, 4);
    send(96'hFE0101EF, 4);
    idle(2);
    check("commit.drop", {n_ok, n_st, bus.busy},
          {32'd1, 32'd1, 1'b0});

    // byte during ABORT is dropped
    clr();
    send(96'hFE0107, 3);
    send(96'hFE0101EF, 4);
    idle(2);
    check("abort.drop", {n_ok, n_err, n_st, bus.busy},
          {32'd0, 32'd1, 32'd0, 1'b0});

    // reset mid-frame: no flush, everything cleared
    clr();
    send(96'hFE0A040102, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst.mid", {bus.busy, bus.row_wr, bus.vec_wr,
                      bus.fifo_flush, bus.frame_err, bus.n_cfg,
                      bus.err_code}, 64'h0);
    rst = 1'b0;
    idle(2);
    check("rst.noflush", {n_fl, n_err}, 0);

    // random frames against the reference model
    m_n = 0;
    for (int f = 0; f < 150; f++) begin
      m_rf = ($urandom_range(0, 6) == 0)
           ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      m_vf = ($urandom_range(0, 9) == 0);
      gen_frame();
      model_frame();
      bus.row_full = m_rf;
      bus.vec_full = m_vf;
      clr();
      repeat ($urandom_range(0, 2)) begin
        w[7:0] = 8'($urandom_range(0, 255));
        if (w[7:0] == 8'hFE) w[7:0] = 8'h00;
        drive(1'b1, w[7:0], 1'b0);
      end
      for (int i = 0; i < m_used; i++) begin
        drive(1'b1, fr[i], 1'b0);
        repeat ($urandom_range(0, 2)) drive(1'b0, 8'h00, 1'b0);
      end
      idle(3);
      check($sformatf("rnd%0d.out", f),
            outc(n_ok, n_err, code_seen, n_st, n_rp, n_fl),
            outc(m_ok, 1 - m_ok, m_code, m_st, m_rp, 1 - m_ok));
      mism = n_oh;
      if (row_q.size() == exp_row.size()) begin
        for (int i = 0; i < row_q.size(); i++)
          if (row_q[i] != exp_row[i]) mism++;
      end
      if (vec_q.size() == exp_vec.size()) begin
        for (int i = 0; i < vec_q.size(); i++)
          if (vec_q[i] != exp_vec[i]) mism++;
      end
      check($sformatf("rnd%0d.wr", f),
            {16'(row_q.size()), 16'(vec_q.size()), 16'(mism)},
            {16'(exp_row.size()), 16'(exp_vec.size()), 16'd0});
      check($sformatf("rnd%0d.ncfg", f), bus.n_cfg, m_n);
      bus.row_full = 8'h00;
      bus.vec_full = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
